// File: rtl/cache_pkg.sv
// Shared address-split constants and layout for the direct-mapped cache.
// cache_addr_t gives control logic and tag RAM one identical field split.
package cache_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int INDEX_BITS  = 5;
    localparam int WORD_BITS   = 2;
    localparam int OFFSET_BITS = 3;
    localparam int TAG_BITS    =
        ADDR_WIDTH - INDEX_BITS - WORD_BITS - OFFSET_BITS;
    localparam int NUM_LINES   = 2 ** INDEX_BITS;

    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [INDEX_BITS-1:0]  index;
        logic [WORD_BITS-1:0]   word_sel;
        logic [OFFSET_BITS-1:0] byte_off;
    } cache_addr_t;

    function automatic cache_addr_t to_cache_addr(
        input logic [ADDR_WIDTH-1:0] a
    );
        return cache_addr_t'(a);
    endfunction

endpackage

// File: rtl/cache_addr_decoder_onehot.sv
// Combinational binary-to-one-hot decoder (line, way or bank select).
// Ports: bin (N_IN bits) in, onehot (2**N_IN bits) out.
module onehot_decoder #(
    parameter int N_IN = 5
) (
    input  logic [N_IN-1:0]      bin,
    output logic [2**N_IN-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/cache_addr_decoder.sv
// Registers a CPU byte address and splits it into tag/index/word/byte fields.
// Ports: clk, rst, in_valid, addr in; out_valid, fields, line_sel, aligned, addr_q out.
module cache_addr_decoder #(
    parameter  int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter  int INDEX_BITS  = cache_pkg::INDEX_BITS,
    parameter  int WORD_BITS   = cache_pkg::WORD_BITS,
    parameter  int OFFSET_BITS = cache_pkg::OFFSET_BITS,
    localparam int TAG_BITS    =
        ADDR_WIDTH - INDEX_BITS - WORD_BITS - OFFSET_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ADDR_WIDTH-1:0]    addr,
    output logic                     out_valid,
    output logic [TAG_BITS-1:0]      tag,
    output logic [INDEX_BITS-1:0]    index,
    output logic [WORD_BITS-1:0]     word_sel,
    output logic [OFFSET_BITS-1:0]   byte_off,
    output logic [2**INDEX_BITS-1:0] line_sel,
    output logic                     aligned,
    output logic [ADDR_WIDTH-1:0]    addr_q
);

    localparam int WORD_LO  = OFFSET_BITS;
    localparam int INDEX_LO = OFFSET_BITS + WORD_BITS;
    localparam int TAG_LO   = INDEX_LO + INDEX_BITS;

    if (TAG_BITS < 1) begin : g_bad_split
        $error("cache_addr_decoder: TAG_BITS must be at least 1");
    end

    // Set by the first accepted address; keeps line_sel all-zero
    // after reset even though the cleared index decodes to line 0.
    logic loaded;
    logic [2**INDEX_BITS-1:0] line_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            addr_q    <= '0;
            loaded    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                addr_q <= addr;
                loaded <= 1'b1;
            end
        end
    end

    assign byte_off = addr_q[OFFSET_BITS-1:0];
    assign word_sel = addr_q[INDEX_LO-1:WORD_LO];
    assign index    = addr_q[TAG_LO-1:INDEX_LO];
    assign tag      = addr_q[ADDR_WIDTH-1:TAG_LO];
    assign aligned  = (byte_off == '0);

    onehot_decoder #(
        .N_IN   (INDEX_BITS)
    ) u_line_dec (
        .bin    (index),
        .onehot (line_dec)
    );

    assign line_sel = loaded ? line_dec : '0;

endmodule

// File: tb/tb_cache_addr_decoder.sv
// Directed and random checks of cache_addr_decoder at default parameters.
// Output bundle: {out_valid, tag, index, word_sel, byte_off, line_sel, aligned, addr_q}.
module tb_cache_addr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] addr;
    logic        out_valid;
    logic [5:0]  tag;
    logic [4:0]  index;
    logic [1:0]  word_sel;
    logic [2:0]  byte_off;
    logic [31:0] line_sel;
    logic        aligned;
    logic [15:0] addr_q;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_addr_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .addr      (addr),
        .out_valid (out_valid),
        .tag       (tag),
        .index     (index),
        .word_sel  (word_sel),
        .byte_off  (byte_off),
        .line_sel  (line_sel),
        .aligned   (aligned),
        .addr_q    (addr_q)
    );

    function automatic logic [65:0] obs();
        return {out_valid, tag, index, word_sel, byte_off,
                line_sel, aligned, addr_q};
    endfunction

    function automatic logic [65:0] bundle(
        input logic v, input logic [5:0] t, input logic [4:0] i,
        input logic [1:0] w, input logic [2:0] b,
        input logic [31:0] ls, input logic al, input logic [15:0] aq
    );
        return {v, t, i, w, b, ls, al, aq};
    endfunction

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [15:0] a, input logic v);
        @(negedge clk);
        addr     = a;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] e;
        #2;
        e = bundle(0, 0, 0, 0, 0, 32'h0, 1, 16'h0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs(), e);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(16'h5555, 1'b0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_decode();
        logic [65:0] e;
        apply(16'hA3F2, 1'b1);
        e = bundle(1, 6'b101000, 5'b11111, 2'b10, 3'b010,
                   32'h8000_0000, 0, 16'hA3F2);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL decode_A3F2: got %h want %h", obs(), e);
        end
        apply(16'hF073, 1'b1);
        e = bundle(1, 6'b111100, 5'b00011, 2'b10, 3'b011,
                   32'h0000_0008, 0, 16'hF073);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL decode_F073: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_back_to_back();
        logic [65:0] e;
        logic [65:0] prev;
        prev = obs();
        @(negedge clk);
        addr = 16'h1234;
        in_valid = 1'b1;
        #2;
        vectors++;
        if (obs() !== prev) begin
            miscompares++;
            $display("FAIL pre_edge_lag: got %h want %h", obs(), prev);
        end
        @(posedge clk);
        #1;
        e = bundle(1, 6'b000100, 5'b10001, 2'b10, 3'b100,
                   32'h0002_0000, 0, 16'h1234);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL stream_1234: got %h want %h", obs(), e);
        end
        apply(16'hFFFF, 1'b1);
        e = bundle(1, 6'b111111, 5'b11111, 2'b11, 3'b111,
                   32'h8000_0000, 0, 16'hFFFF);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL stream_FFFF: got %h want %h", obs(), e);
        end
        apply(16'h0000, 1'b1);
        e = bundle(1, 0, 0, 0, 0, 32'h0000_0001, 1, 16'h0000);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL stream_0000: got %h want %h", obs(), e);
        end
        apply(16'hFFFF, 1'b0);
        e = bundle(0, 0, 0, 0, 0, 32'h0000_0001, 1, 16'h0000);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL hold_invalid: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [65:0] e;
        apply(16'hA3F2, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        e = bundle(0, 0, 0, 0, 0, 32'h0, 1, 16'h0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL async_clear: got %h want %h", obs(), e);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(16'h0008, 1'b1);
        e = bundle(1, 0, 0, 2'b01, 3'b000, 32'h0000_0001, 1, 16'h0008);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL post_reset_0008: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] ea;
        logic        v;
        logic        ld;
        logic [65:0] e;
        ea = 16'h0008;
        ld = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            v = 1'($urandom_range(0, 1));
            apply(v ? a : 16'hxxxx, v);
            if (v) begin
                ea = a;
                ld = 1'b1;
            end
            e = bundle(v, ea[15:10], ea[9:5], ea[4:3], ea[2:0],
                       ld ? (32'h1 << ea[9:5]) : 32'h0,
                       ea[2:0] == 3'b000, ea);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL random_%0d: got %h want %h", n, obs(), e);
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if ($countones(line_sel) != 1) begin
                    miscompares++;
                    $display("FAIL onehot_%0d: got %h want one bit set",
                             n, line_sel);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        addr     = 16'h0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
